// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
//
// Purpose:
//   Instruction-memory bus between the fetch stage and instruction memory.
//   It carries a valid/ready request channel and a valid-only response channel.
//
// Signals:
//   imem_req_valid  fetch request valid          (fetch stage -> memory)
//   imem_req_addr   32-bit fetch address         (fetch stage -> memory)
//   imem_req_ready  memory accepts the request   (memory -> fetch stage)
//   imem_rsp_valid  instruction word returned    (memory -> fetch stage)
//   imem_rsp_data   32-bit instruction word      (memory -> fetch stage)
//
// Modports:
//   master  the fetch stage side
//   slave   the instruction memory side
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Purpose:
//   Instruction-fetch stage of the RV32I pipeline. It holds the PC register
//   (PCF), fetches one instruction at a time from instruction memory, and
//   writes the IF/ID pipeline register (PCD, InstrD, ValidD). A word that comes
//   back while ID is stalled is parked in a hold buffer. A response to a
//   request that was overtaken by a redirect is discarded.
//
// Optional feature:
//   IF_PERF_CNT_EN  when defined, FetchCnt and BubbleCnt are live performance
//                   counters. When undefined, both outputs are constant 0 and
//                   no counter registers exist.
//
// Parameters:
//   RESET_PC   value loaded into PCF by reset
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   PC_In      next PC from NPC_Generator (PCF+4 or redirect target)
//   StallD     ID cannot accept; IF/ID holds
//   FlushD     redirect; PC_In carries the target
//   imem       instruction-memory bus (master modport)
//   PCF        current fetch PC
//   PCD        IF/ID PC
//   InstrD     IF/ID instruction word
//   ValidD     IF/ID holds a real instruction
//   FetchCnt   instructions written into IF/ID
//   BubbleCnt  bubbles written into IF/ID
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        PC_In,
    input  logic               StallD,
    input  logic               FlushD,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        PCF,
    output logic [31:0]        PCD,
    output logic [31:0]        InstrD,
    output logic               ValidD,
    output logic [31:0]        FetchCnt,
    output logic [31:0]        BubbleCnt
);

    localparam logic [1:0]  S_REQ  = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_HOLD = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]  r_state;
    logic        r_stale;
    logic [31:0] r_pcF;
    logic [31:0] r_pcD;
    logic [31:0] r_instrD;
    logic        r_validD;
    logic [31:0] r_holdBuf;

    logic        w_rspUsable;
    logic        w_write;
    logic [31:0] w_instr;

    // A response is only usable when it belongs to the current PCF, i.e. no
    // redirect happened while it was in flight.
    assign w_rspUsable = (r_state == S_WAIT) && imem.imem_rsp_valid && !r_stale;

    // An instruction enters IF/ID this cycle: either straight from memory or
    // from the hold buffer, and only when ID can take it and nothing flushes.
    assign w_write = !FlushD && !StallD && (w_rspUsable || (r_state == S_HOLD));

    assign w_instr = (r_state == S_HOLD) ? r_holdBuf : imem.imem_rsp_data;

    // Request outputs come straight from registered state, so req_ready can
    // never loop back combinationally into req_valid.
    assign imem.imem_req_valid = (r_state == S_REQ);
    assign imem.imem_req_addr  = r_pcF;

    assign PCF    = r_pcF;
    assign PCD    = r_pcD;
    assign InstrD = r_instrD;
    assign ValidD = r_validD;

    // Fetch FSM, PC register and IF/ID register. FlushD overrides everything
    // else; the only per-state question under a flush is whether a request is
    // still in flight (mark it stale) or already finished (nothing to track).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_REQ;
            r_stale   <= 1'b0;
            r_pcF     <= RESET_PC;
            r_pcD     <= 32'h0000_0000;
            r_instrD  <= NOP_INSTR;
            r_validD  <= 1'b0;
            r_holdBuf <= 32'h0000_0000;
        end else if (FlushD) begin
            r_pcF    <= PC_In;
            r_validD <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (imem.imem_req_ready) begin
                        r_stale <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving now is dropped and closes the
                    // outstanding request, so nothing is left to mark stale.
                    if (imem.imem_rsp_valid) begin
                        r_stale <= 1'b0;
                        r_state <= S_REQ;
                    end else begin
                        r_stale <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_REQ;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end else begin
            if (w_write) begin
                r_pcD    <= r_pcF;
                r_instrD <= w_instr;
                r_validD <= 1'b1;
                r_pcF    <= PC_In;
            end else if (!StallD) begin
                r_validD <= 1'b0;
            end

            case (r_state)
                S_REQ: begin
                    if (imem.imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (r_stale) begin
                            r_stale <= 1'b0;
                            r_state <= S_REQ;
                        end else if (!StallD) begin
                            r_state <= S_REQ;
                        end else begin
                            r_holdBuf <= imem.imem_rsp_data;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetchCnt;
    logic [31:0] r_bubbleCnt;
    logic        w_bubble;

    // A bubble is any cycle where ID advances without receiving an
    // instruction; flush cycles fall out of this naturally.
    assign w_bubble = !StallD && !w_write;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetchCnt  <= 32'h0000_0000;
            r_bubbleCnt <= 32'h0000_0000;
        end else begin
            if (w_write) begin
                r_fetchCnt <= r_fetchCnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubbleCnt <= r_bubbleCnt + 32'd1;
            end
        end
    end

    assign FetchCnt  = r_fetchCnt;
    assign BubbleCnt = r_bubbleCnt;
`else
    assign FetchCnt  = 32'h0000_0000;
    assign BubbleCnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Purpose:
//   Self-checking bench for if_fetch_stage. The bench plays NPC_Generator
//   (PC_In = PCF+4 unless a redirect is driven) and a behavioural instruction
//   memory with configurable response latency. Expected IF/ID contents are
//   queued as each scenario is driven and compared whenever the stage writes
//   a new instruction into IF/ID.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC_In;
    logic        StallD;
    logic        FlushD;
    logic [31:0] PCF;
    logic [31:0] PCD;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [31:0] FetchCnt;
    logic [31:0] BubbleCnt;

    logic        redirect;
    logic [31:0] target;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } expEntry_t;

    expEntry_t sbQ[$];

    int vecCount     = 0;
    int missCount    = 0;
    int cycleCnt     = 0;
    int prevWriteCyc = 0;
    int lastWriteCyc = 0;
    int memLatency   = 0;

    if_fetch_stage_if imemBus();

    // 100 MHz-style clock, period 10.
    always #5 clk = ~clk;

    // Bench acts as NPC_Generator: sequential flow unless a redirect is driven.
    assign PC_In = redirect ? target : (PCF + 32'd4);

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC_In     (PC_In),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .imem      (imemBus.master),
        .PCF       (PCF),
        .PCD       (PCD),
        .InstrD    (InstrD),
        .ValidD    (ValidD),
        .FetchCnt  (FetchCnt),
        .BubbleCnt (BubbleCnt)
    );

    // Instruction memory image.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: memWord = 32'h0050_0093;
            32'h0000_0004: memWord = 32'h00A0_0113;
            default:       memWord = {addr[19:0], 12'h013};
        endcase
    endfunction

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input logic [31:0] pc);
        expEntry_t e;
        e.pc    = pc;
        e.instr = memWord(pc);
        sbQ.push_back(e);
    endtask

    // Advance one clock and land 3 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic stall,
                                 input logic flush, input logic [31:0] tgt);
        rst_n                  = rst;
        imemBus.imem_req_ready = rdy;
        StallD                 = stall;
        FlushD                 = flush;
        redirect               = flush;
        target                 = tgt;
    endtask

    // Wait (bounded) until every queued instruction has been seen in IF/ID.
    task automatic drain(input int budget);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_timeout", sbQ.size(), 0);
    endtask

    function automatic logic [31:0] perfExp(input logic [31:0] v);
`ifdef IF_PERF_CNT_EN
        perfExp = v;
`else
        perfExp = 32'h0000_0000;
`endif
    endfunction

    // Behavioural memory: sees an accepted request mid-cycle and returns the
    // word memLatency+1 cycles later as a one-cycle pulse. Reset clears it.
    initial begin
        logic        pend;
        logic [31:0] pendAddr;
        int          delay;
        pend     = 1'b0;
        pendAddr = 32'h0;
        delay    = 0;
        imemBus.imem_rsp_valid = 1'b0;
        imemBus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pend = 1'b0;
                imemBus.imem_rsp_valid = 1'b0;
            end else begin
                imemBus.imem_rsp_valid = 1'b0;
                if (pend) begin
                    if (delay == 0) begin
                        imemBus.imem_rsp_valid = 1'b1;
                        imemBus.imem_rsp_data  = memWord(pendAddr);
                        pend = 1'b0;
                    end else begin
                        delay--;
                    end
                end
                if (imemBus.imem_req_valid === 1'b1 && imemBus.imem_req_ready === 1'b1) begin
                    pend     = 1'b1;
                    pendAddr = imemBus.imem_req_addr;
                    delay    = memLatency;
                end
            end
        end
    end

    // Scoreboard monitor: after an edge where ID was not stalled, ValidD=1
    // means a new instruction was written, so it must match the queue head.
    initial begin
        logic stallAtEdge;
        logic rstAtEdge;
        expEntry_t e;
        forever begin
            @(posedge clk);
            stallAtEdge = StallD;
            rstAtEdge   = rst_n;
            cycleCnt++;
            #2;
            if (rstAtEdge === 1'b1 && stallAtEdge === 1'b0 && ValidD === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sb_extra_write", {31'b0, ValidD}, 32'h0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_pcd", PCD, e.pc);
                    checkOutput("sb_instr", InstrD, e.instr);
                end
                prevWriteCyc = lastWriteCyc;
                lastWriteCyc = cycleCnt;
            end
        end
    end

    initial begin
        logic [31:0] bubbleBase;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state.
        tick();
        tick();
        checkOutput("rst_pcf", PCF, 32'h0000_0000);
        checkOutput("rst_pcd", PCD, 32'h0000_0000);
        checkOutput("rst_instrd", InstrD, 32'h0000_0013);
        checkOutput("rst_validd", {31'b0, ValidD}, 32'h0);
        checkOutput("rst_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h1);
        checkOutput("rst_fetchcnt", FetchCnt, 32'h0);
        checkOutput("rst_bubblecnt", BubbleCnt, 32'h0);

        // Zero-wait sequential fetch of 0x0 and 0x4.
        pushExpect(32'h0);
        pushExpect(32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drain(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("throughput_gap", lastWriteCyc - prevWriteCyc, 32'd2);
        checkOutput("fetchcnt_after_two", FetchCnt, perfExp(32'd2));

        // Memory not ready for 3 cycles: request held steady, bubbles counted.
        bubbleBase = BubbleCnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("notready_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h1);
            checkOutput("notready_req_addr", imemBus.imem_req_addr, 32'h8);
            checkOutput("notready_validd", {31'b0, ValidD}, 32'h0);
        end
        checkOutput("notready_bubblecnt", BubbleCnt, perfExp(bubbleBase + 32'd3));

        // Response arrives while ID is stalled: buffered, then released.
        pushExpect(32'h8);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("hold_pcf", PCF, 32'h8);
        checkOutput("hold_pcd", PCD, 32'h4);
        checkOutput("hold_instrd", InstrD, 32'h00A0_0113);
        tick();
        checkOutput("hold2_pcf", PCF, 32'h8);
        checkOutput("hold2_validd", {31'b0, ValidD}, 32'h0);
        checkOutput("hold2_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drain(5);
        checkOutput("release_pcf", PCF, 32'hC);

        // Redirect while waiting on a slow response: late word must be dropped.
        memLatency = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("flushwait_validd", {31'b0, ValidD}, 32'h0);
        checkOutput("flushwait_pcf", PCF, 32'h100);
        checkOutput("flushwait_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h0);
        pushExpect(32'h100);
        tick();
        tick();
        checkOutput("stale_drop_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h1);
        checkOutput("stale_drop_req_addr", imemBus.imem_req_addr, 32'h100);
        drain(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        memLatency = 0;

        // Redirect in the same cycle the response arrives.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("flushrsp_validd", {31'b0, ValidD}, 32'h0);
        checkOutput("flushrsp_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h1);
        checkOutput("flushrsp_req_addr", imemBus.imem_req_addr, 32'h200);
        pushExpect(32'h200);
        drain(10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset while an instruction is parked in the hold buffer.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("prereset_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("midrst_pcf", PCF, 32'h0);
        checkOutput("midrst_validd", {31'b0, ValidD}, 32'h0);
        checkOutput("midrst_instrd", InstrD, 32'h0000_0013);
        checkOutput("midrst_req_valid", {31'b0, imemBus.imem_req_valid}, 32'h1);
        checkOutput("midrst_fetchcnt", FetchCnt, 32'h0);
        checkOutput("midrst_bubblecnt", BubbleCnt, 32'h0);

        // Fetch resumes cleanly from RESET_PC.
        pushExpect(32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drain(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
